// File: rtl/spi_ram_rx.sv
// spi_ram_rx: SPI mode-0 slave receiver that captures MSB-first bytes into an
// internal byte buffer at an auto-incrementing address. The processing side
// reads the buffer through a registered read port.
// Optional build macro SPI_RAM_RX_CHECKSUM_EN adds a modulo-256 checksum output
// covering all bytes stored since the last start.
module spi_ram_rx #(
   parameter int ADDR_W      = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_l,
   input  logic              start,
   input  logic [ADDR_W-1:0] end_addr,
   input  logic              sclk,
   input  logic              mosi,
   input  logic              cs,
   output logic              byte_valid,
   output logic [7:0]        rx_byte,
   output logic [ADDR_W-1:0] wr_ptr,
   output logic              busy,
   output logic              done,
   output logic              frame_err,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [7:0]        rd_data
`ifdef SPI_RAM_RX_CHECKSUM_EN
   ,
   output logic [7:0]        checksum
`endif
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARMED,
      ST_SHIFT,
      ST_STORE,
      ST_DONE
   } state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
   logic                   sclk_prev_q, sclk_prev_d;
   logic                   cs_prev_q, cs_prev_d;
   logic [2:0]             bit_cnt_q, bit_cnt_d;
   logic [7:0]             shift_q, shift_d;
   logic [ADDR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [7:0]             rx_byte_q, rx_byte_d;
   logic                   byte_valid_q, byte_valid_d;
   logic                   frame_err_q, frame_err_d;
   logic [7:0]             rd_data_q, rd_data_d;
`ifdef SPI_RAM_RX_CHECKSUM_EN
   logic [7:0]             checksum_q, checksum_d;
`endif

   logic [7:0]             mem [0:(1<<ADDR_W)-1];
   logic                   mem_we;
   logic [ADDR_W-1:0]      wr_ptr_inc;

   // Synchronized SPI pins and their edges (mosi is aligned with sclk)
   logic sclk_s, mosi_s, cs_s;
   logic sclk_rise, cs_fall, cs_rise;

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign cs_s      = cs_sync_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_prev_q;
   assign cs_fall   = ~cs_s & cs_prev_q;
   assign cs_rise   = cs_s & ~cs_prev_q;

   // Next-state, datapath and output decode; start overrides everything else
   always_comb begin
      // NOTE: every variable gets a default before the case so no latch is inferred.
      state_d      = state_q;
      sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      mosi_sync_d  = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      cs_sync_d    = {cs_sync_q[SYNC_STAGES-2:0], cs};
      sclk_prev_d  = sclk_s;
      cs_prev_d    = cs_s;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      wr_ptr_d     = wr_ptr_q;
      rx_byte_d    = rx_byte_q;
      byte_valid_d = 1'b0;
      frame_err_d  = 1'b0;
      mem_we       = 1'b0;
      wr_ptr_inc   = wr_ptr_q + ADDR_W'(1);
      rd_data_d    = mem[rd_addr];
`ifdef SPI_RAM_RX_CHECKSUM_EN
      checksum_d   = checksum_q;
`endif

      case (state_q)
         ST_ARMED: begin
            if (cs_fall) begin
               state_d   = ST_SHIFT;
               bit_cnt_d = 3'd0;
            end
         end
         ST_SHIFT: begin
            if (cs_rise) begin
               // A cs rise right after a complete byte carries no partial data.
               frame_err_d = (bit_cnt_q != 3'd0);
               bit_cnt_d   = 3'd0;
               state_d     = ST_ARMED;
            end else if (sclk_rise && !cs_s) begin
               shift_d   = {shift_q[6:0], mosi_s};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = ST_STORE;
               end
            end
         end
         ST_STORE: begin
            mem_we       = 1'b1;
            rx_byte_d    = shift_q;
            byte_valid_d = 1'b1;
            wr_ptr_d     = wr_ptr_inc;
            bit_cnt_d    = 3'd0;
`ifdef SPI_RAM_RX_CHECKSUM_EN
            checksum_d   = checksum_q + shift_q;
`endif
            // Truncated compare makes end_addr=0 mean a full 2^ADDR_W run.
            if (wr_ptr_inc == end_addr) begin
               state_d = ST_DONE;
            end else if (!cs_s) begin
               state_d = ST_SHIFT;
            end else begin
               state_d = ST_ARMED;
            end
         end
         default: ;
      endcase

      if (start) begin
         state_d      = ST_ARMED;
         bit_cnt_d    = 3'd0;
         wr_ptr_d     = '0;
         rx_byte_d    = rx_byte_q;
         byte_valid_d = 1'b0;
         frame_err_d  = 1'b0;
         mem_we       = 1'b0;
`ifdef SPI_RAM_RX_CHECKSUM_EN
         checksum_d   = 8'd0;
`endif
      end
   end

   // Control and datapath registers
   always_ff @(posedge clk or negedge rst_l) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (!rst_l) begin
         state_q      <= ST_IDLE;
         sclk_sync_q  <= '0;
         mosi_sync_q  <= '0;
         cs_sync_q    <= '1;
         sclk_prev_q  <= 1'b0;
         cs_prev_q    <= 1'b1;
         bit_cnt_q    <= 3'd0;
         shift_q      <= 8'd0;
         wr_ptr_q     <= '0;
         rx_byte_q    <= 8'd0;
         byte_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         rd_data_q    <= 8'd0;
`ifdef SPI_RAM_RX_CHECKSUM_EN
         checksum_q   <= 8'd0;
`endif
      end else begin
         state_q      <= state_d;
         sclk_sync_q  <= sclk_sync_d;
         mosi_sync_q  <= mosi_sync_d;
         cs_sync_q    <= cs_sync_d;
         sclk_prev_q  <= sclk_prev_d;
         cs_prev_q    <= cs_prev_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         wr_ptr_q     <= wr_ptr_d;
         rx_byte_q    <= rx_byte_d;
         byte_valid_q <= byte_valid_d;
         frame_err_q  <= frame_err_d;
         rd_data_q    <= rd_data_d;
`ifdef SPI_RAM_RX_CHECKSUM_EN
         checksum_q   <= checksum_d;
`endif
      end
   end

   // Byte buffer write port; a same-cycle read sees the old contents
   always_ff @(posedge clk) begin
      // NOTE: the buffer has no reset so it maps onto plain RAM.
      if (mem_we) begin
         mem[wr_ptr_q] <= shift_q;
      end
   end

   assign byte_valid = byte_valid_q;
   assign rx_byte    = rx_byte_q;
   assign wr_ptr     = wr_ptr_q;
   assign busy       = (state_q == ST_ARMED) || (state_q == ST_SHIFT) || (state_q == ST_STORE);
   assign done       = (state_q == ST_DONE);
   assign frame_err  = frame_err_q;
   assign rd_data    = rd_data_q;
`ifdef SPI_RAM_RX_CHECKSUM_EN
   assign checksum   = checksum_q;
`endif

endmodule

// File: doc/spi_ram_rx.md
Name: spi_ram_rx

Overview:
- SPI mode-0 slave receiver; the capture-side counterpart of the SPI-master byte streamer.
- Samples sclk/mosi/cs on the system clock and assembles MSB-first bytes.
- Writes each byte into an internal byte buffer at an auto-incrementing address until end_addr bytes have arrived.
- The FFT/processing side reads the captured samples through a registered read port.

Parameters:
- ADDR_W, 8, buffer address width; depth = 2^ADDR_W bytes.
- SYNC_STAGES, 2, synchronizer flops on sclk, mosi and cs (min 2).

Ports:
- clk  in  1  system clock
- rst_l  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse: arm or re-arm capture, write pointer to 0
- end_addr  in  ADDR_W  number of bytes per capture; 0 means 2^ADDR_W
- sclk  in  1  SPI clock from master (CPOL=0)
- mosi  in  1  SPI data from master
- cs  in  1  SPI chip select, active low
- byte_valid  out  1  one-cycle pulse when a byte is written to the buffer
- rx_byte  out  8  last received byte, held until the next byte
- wr_ptr  out  ADDR_W  number of bytes captured in the current run
- busy  out  1  high from start until done
- done  out  1  high once end_addr bytes are captured; held until start
- frame_err  out  1  one-cycle pulse when cs deasserts mid-byte
- rd_addr  in  ADDR_W  buffer read address
- rd_data  out  8  buffer data, one-cycle registered latency

Behaviour:
- Reset values: all outputs 0, state IDLE, bit counter 0. Buffer contents are not reset.
- Input sync: sclk, mosi and cs each pass through SYNC_STAGES flops. Edges are detected on synchronized values.
- Clock ratio: sclk high and low phases must each be >= 2 clk periods; the block does not need to support faster sclk.
- Sampling: mosi is sampled on each synchronized sclk rising edge while synchronized cs=0. Bits shift in MSB first.
- IDLE: ignores the SPI pins. start -> ARMED with wr_ptr=0, busy=1, done=0.
- ARMED: waits for a synchronized cs falling edge, or cs already low after STORE. Then -> SHIFT with bit count 0.
- SHIFT:
  - Count sclk rising edges. On the 8th -> STORE.
  - Synchronized cs rising before 8 bits: discard the partial byte, pulse frame_err, -> ARMED. wr_ptr is unchanged.
- STORE (one cycle):
  - mem[wr_ptr] <= byte, rx_byte <= byte, byte_valid=1, wr_ptr+1.
  - If the new count equals end_addr (0 -> 2^ADDR_W) -> DONE.
  - Else if cs still low -> SHIFT, so multi-byte transfers under one cs are supported.
  - Else -> ARMED.
- DONE: busy=0, done=1. SPI activity is ignored. start -> ARMED.
- Latency: byte_valid rises at most SYNC_STAGES+2 clk cycles after the clk edge that first samples the 8th sclk high.
- Wrap: wr_ptr cannot exceed end_addr. With end_addr=0, the 256th byte lands at address 255 and then DONE. There is no overwrite past the end.
- start in any non-IDLE state restarts capture: partial byte dropped, no frame_err, wr_ptr=0, done=0.
- start in the same cycle as STORE: start wins and the byte is not written.
- Read port:
  - rd_data <= mem[rd_addr] on every clk; reads are legal in any state.
  - Same-cycle read and write to one address returns the old data.
- Reset asserted mid-byte: returns to IDLE immediately. The next capture needs a new start.

Optional Feature:
- Macro: SPI_RAM_RX_CHECKSUM_EN.
- Defined:
  - Adds output port checksum[7:0], an 8-bit modulo-256 sum of all bytes stored since the last start.
  - Cleared by start and by reset; updated in the STORE cycle. Valid together with done.
- Undefined: no checksum port or logic. All other behaviour is identical.

Test Plan:
- Reset, start, end_addr=4, master sends 0x02,0x05,0x08,0x0B, one byte per cs cycle, sclk=clk/8 -> four byte_valid pulses, done=1, wr_ptr=4; reading addr 0..3 gives 02,05,08,0B one cycle after each rd_addr.
- end_addr=3, single cs low for 24 sclk carrying 0x7F,0x7E,0x7D -> done=1, mem[0..2]=7F,7E,7D, no frame_err.
- end_addr=2; send 5 bits then raise cs, then full byte 0x59 and 0x57 -> one frame_err pulse, mem[0]=0x59, mem[1]=0x57, done=1.
- After done, master sends 0xAA -> no byte_valid, mem unchanged. Then start: done=0, busy=1, wr_ptr=0.
- rst_l pulsed low during bit 4 of a byte -> all outputs 0 immediately. Further SPI traffic ignored until start.
- With SPI_RAM_RX_CHECKSUM_EN: end_addr=3, bytes 0xF0,0x20,0x05 -> checksum=0x15 at done.
